// File: rtl/event_encoder.sv
// event_encoder: latches single-cycle event pulses on N request lines into a
// pending set and drains them as binary indices over a valid/ready stream.
// Selection is either lowest-index-first or round-robin after the last grant.
// Every output comes straight from a flop; no input reaches an output
// combinationally.
module event_encoder #(
  parameter int N           = 4,
  parameter int W           = 2,
  parameter int ROUND_ROBIN = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         clr,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  output logic [N-1:0] pending,
  output logic         ovf
);

  // Output stage: IDLE has nothing presented, HOLD presents out_code_q.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]   state_q,      state_d;
  logic [W-1:0] out_code_q,   out_code_d;
  logic [N-1:0] pending_q,    pending_d;
  logic         ovf_q,        ovf_d;
  logic [W-1:0] last_grant_q, last_grant_d;

  logic         hold;
  logic         ack;
  logic [N-1:0] cur_oh;
  logic [N-1:0] ack_mask;
  logic [N-1:0] cand;
  logic         load;
  logic [W-1:0] lo_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] rr_probe;
  logic         rr_found;
  logic [W-1:0] sel_idx;

  // Handshake and candidate set; the presented bit is masked so it is never
  // picked again while it is still on the bus.
  // NOTE: every signal written in an always_comb gets a default before any
  // branch, otherwise a path that skips the assignment infers a latch.
  always_comb begin
    cur_oh             = '0;
    cur_oh[out_code_q] = 1'b1;
    hold               = (state_q == ST_HOLD);
    ack                = hold & out_ready;
    ack_mask           = ack ? cur_oh : '0;
    cand               = hold ? (pending_q & ~cur_oh) : pending_q;
  end

  // Fixed priority: scanning from the top down lets the lowest set bit win.
  always_comb begin
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) lo_idx = W'(i);
    end
  end

  // Round robin: probe indices starting just after the last grant; the W-bit
  // sum wraps naturally because N is a power of two.
  always_comb begin
    rr_idx   = '0;
    rr_probe = '0;
    rr_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      rr_probe = last_grant_q + W'(1) + W'(k);
      if (!rr_found && cand[rr_probe]) begin
        rr_idx   = rr_probe;
        rr_found = 1'b1;
      end
    end
  end

  // Next-state logic: pending/overflow update, output stage, then clr on top.
  always_comb begin
    sel_idx      = (ROUND_ROBIN != 0) ? rr_idx : lo_idx;
    load         = ((state_q == ST_IDLE) || ack) && (|cand);
    state_d      = state_q;
    out_code_d   = out_code_q;
    last_grant_d = last_grant_q;
    // A request landing on the bit being acked re-arms it without overflow.
    pending_d    = (pending_q & ~ack_mask) | req;
    ovf_d        = ovf_q | (|(req & pending_q & ~ack_mask));

    if (load) begin
      state_d      = ST_HOLD;
      out_code_d   = sel_idx;
      last_grant_d = sel_idx;
    end else if (ack) begin
      state_d      = ST_IDLE;
    end

    // clr drops everything in flight (including same-cycle requests) but
    // keeps the code on the bus and the round-robin position.
    if (clr) begin
      state_d      = ST_IDLE;
      pending_d    = '0;
      ovf_d        = 1'b0;
      out_code_d   = out_code_q;
      last_grant_d = last_grant_q;
    end
  end

  // State registers; last_grant starts at N-1 so the first search begins at 0.
  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      out_code_q   <= '0;
      pending_q    <= '0;
      ovf_q        <= 1'b0;
      last_grant_q <= W'(N - 1);
    end else begin
      state_q      <= state_d;
      out_code_q   <= out_code_d;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_code  = out_code_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_event_encoder.sv
// tb_event_encoder: drives one fixed-priority and one round-robin instance
// with shared stimulus. A behavioural model pushes each code it expects to be
// presented into a per-instance queue; a negedge monitor pops and compares on
// every accepted transfer and also compares the visible state every cycle.
`timescale 1ns/1ps
module tb_event_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         out_ready;
  logic [N-1:0] req;

  logic         v0, v1;
  logic [W-1:0] c0, c1;
  logic [N-1:0] p0, p1;
  logic         o0, o1;

  event_encoder #(.N(N), .W(W), .ROUND_ROBIN(0)) u_fixed (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .out_ready(out_ready),
    .out_valid(v0), .out_code(c0), .pending(p0), .ovf(o0)
  );

  event_encoder #(.N(N), .W(W), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr), .out_ready(out_ready),
    .out_valid(v1), .out_code(c1), .pending(p1), .ovf(o1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model (index 0 = fixed, 1 = round robin)
  bit [N-1:0] m_pend [2];
  bit         m_valid[2];
  int         m_code [2];
  int         m_last [2];
  bit         m_ovf  [2];
  int exp_q0[$], exp_q1[$];
  int log0[$],   log1[$];

  function automatic int pick(input int p, input bit [N-1:0] cand);
    if (p == 0) begin
      for (int i = 0; i < N; i++) if (cand[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (cand[(m_last[p] + k) % N]) return (m_last[p] + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = '0; m_valid[p] = 0; m_code[p] = 0; m_last[p] = N - 1; m_ovf[p] = 0;
    end
    exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic model_step(input int p);
    bit [N-1:0] old;
    bit [N-1:0] cand;
    bit         ack;
    int         s;
    old = m_pend[p];
    if (clr) begin
      // A presented but unaccepted code is withdrawn from the expectations.
      if (m_valid[p] && !out_ready) begin
        if (p == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
      end
      m_pend[p] = '0; m_valid[p] = 0; m_ovf[p] = 0;
      return;
    end
    ack = m_valid[p] && out_ready;
    for (int i = 0; i < N; i++)
      if (req[i] && old[i] && !(ack && m_code[p] == i)) m_ovf[p] = 1;
    m_pend[p] = old;
    if (ack) m_pend[p][m_code[p]] = 1'b0;
    m_pend[p] = m_pend[p] | req;
    cand = old;
    if (m_valid[p]) cand[m_code[p]] = 1'b0;
    if (!m_valid[p] || ack) begin
      s = pick(p, cand);
      if (s >= 0) begin
        m_valid[p] = 1; m_code[p] = s; m_last[p] = s;
        if (p == 0) exp_q0.push_back(s); else exp_q1.push_back(s);
      end else begin
        m_valid[p] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  // ---------------- monitor / scoreboard
  task automatic monitor(input int p);
    logic         vld;
    logic [W-1:0] code;
    logic [N-1:0] pend;
    logic         ov;
    int           e;
    string        tag;
    tag  = (p == 0) ? "fx" : "rr";
    vld  = (p == 0) ? v0 : v1;
    code = (p == 0) ? c0 : c1;
    pend = (p == 0) ? p0 : p1;
    ov   = (p == 0) ? o0 : o1;
    check({tag, ".valid"},   vld,  m_valid[p]);
    check({tag, ".pending"}, pend, m_pend[p]);
    check({tag, ".ovf"},     ov,   m_ovf[p]);
    if (m_valid[p]) check({tag, ".code"}, code, m_code[p]);
    if (vld === 1'b1 && out_ready) begin
      if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        check({tag, ".sb_unexpected_accept"}, 1, 0);
      end else begin
        e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check({tag, ".sb_code"}, code, e);
      end
      if (p == 0) log0.push_back(int'(code)); else log1.push_back(int'(code));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        monitor(0);
        monitor(1);
      end
    end
  end

  function automatic int log_at(input int p, input int i);
    if (p == 0) return (i < log0.size()) ? log0[i] : -1;
    return (i < log1.size()) ? log1[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle_reset(input string name);
    check({name, ".fx_valid"}, v0, 0); check({name, ".fx_pending"}, p0, 0);
    check({name, ".fx_code"},  c0, 0); check({name, ".fx_ovf"},     o0, 0);
    check({name, ".rr_valid"}, v1, 0); check({name, ".rr_pending"}, p1, 0);
    check({name, ".rr_code"},  c1, 0); check({name, ".rr_ovf"},     o1, 0);
  endtask

  int burst_fx[3] = '{0, 1, 3};
  int burst_rr[3] = '{3, 0, 1};
  int rot_fx[4]   = '{0, 1, 0, 1};
  int rot_rr[6]   = '{0, 1, 2, 0, 1, 2};

  initial begin
    int twos;
    rst_n = 1'b0; req = '0; clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_idle_reset("reset");
    rst_n = 1'b1;

    // Single event: pending after edge k, valid after k+1, drained after k+2.
    out_ready = 1'b1; req = 4'b0100;
    tick(); req = '0;
    check("single.fx_pending_k", p0, 4'b0100); check("single.fx_valid_k", v0, 0);
    check("single.rr_pending_k", p1, 4'b0100);
    tick();
    check("single.fx_valid_k1", v0, 1); check("single.fx_code_k1", c0, 2);
    check("single.rr_valid_k1", v1, 1); check("single.rr_code_k1", c1, 2);
    tick();
    check("single.fx_pending_k2", p0, 0); check("single.fx_valid_k2", v0, 0);
    check("single.rr_valid_k2", v1, 0);
    tick();

    // Burst: one-cycle 1011, consumer always ready.
    log0.delete(); log1.delete();
    req = 4'b1011;
    tick(); req = '0;
    repeat (5) tick();
    check("burst.fx_count", log0.size(), 3);
    check("burst.rr_count", log1.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("burst.fx_code%0d", i), log_at(0, i), burst_fx[i]);
      check($sformatf("burst.rr_code%0d", i), log_at(1, i), burst_rr[i]);
    end
    check("burst.fx_valid_end", v0, 0);
    check("burst.fx_ovf", o0, 0); check("burst.rr_ovf", o1, 0);

    // Backpressure: code 1 held for 10 cycles, then overflow and re-arm.
    out_ready = 1'b0; req = 4'b0010;
    tick(); req = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold.fx_code_c%0d", i), {v0, c0}, {1'b1, 2'd1});
      check($sformatf("hold.rr_code_c%0d", i), {v1, c1}, {1'b1, 2'd1});
      tick();
    end
    req = 4'b0010;
    tick(); req = '0;
    check("ovf.fx_set", o0, 1); check("ovf.rr_set", o1, 1);
    repeat (3) tick();
    check("ovf.fx_sticky", o0, 1); check("ovf.rr_sticky", o1, 1);
    out_ready = 1'b1; req = 4'b0010;
    tick(); req = '0;
    check("rearm.fx_pending1", p0[1], 1); check("rearm.rr_pending1", p1[1], 1);
    check("rearm.fx_ovf", o0, 1);
    tick();
    check("rearm.fx_code", {v0, c0}, {1'b1, 2'd1});
    repeat (3) tick();
    clr = 1'b1;
    tick(); clr = 1'b0;
    check("clr.fx_ovf", o0, 0); check("clr.rr_ovf", o1, 0);

    // Asynchronous reset in the middle of HOLD with pending = 1010.
    out_ready = 1'b0; req = 4'b1010;
    tick(); req = '0;
    tick();
    check("prereset.fx_valid", v0, 1); check("prereset.fx_pending", p0, 4'b1010);
    check("prereset.rr_pending", p1, 4'b1010);
    rst_n = 1'b0;
    #1;
    check_idle_reset("async_reset");
    tick(); tick();
    rst_n = 1'b1;

    // Rotation with 0111 held: first grant after reset is index 0.
    log0.delete(); log1.delete();
    out_ready = 1'b1; req = 4'b0111;
    repeat (9) tick();
    req = '0;
    for (int i = 0; i < 4; i++) check($sformatf("rot.fx_code%0d", i), log_at(0, i), rot_fx[i]);
    for (int i = 0; i < 6; i++) check($sformatf("rot.rr_code%0d", i), log_at(1, i), rot_rr[i]);
    twos = 0;
    foreach (log0[i]) if (log0[i] == 2) twos++;
    check("rot.fx_no_index2", twos, 0);
    repeat (6) tick();
    clr = 1'b1;
    tick(); clr = 1'b0;

    // clr during HOLD with pending = 1100 and a same-cycle req on bit 0.
    out_ready = 1'b0; req = 4'b1100;
    tick(); req = '0;
    tick();
    check("preclr.fx_code", {v0, c0}, {1'b1, 2'd2});
    clr = 1'b1; req = 4'b0001;
    tick(); clr = 1'b0; req = '0;
    check("clr.fx_valid", v0, 0); check("clr.fx_pending", p0, 0); check("clr.fx_ovf", o0, 0);
    check("clr.rr_valid", v1, 0); check("clr.rr_pending", p1, 0);
    check("clr.fx_code_kept", c0, 2);
    log0.delete(); log1.delete();
    out_ready = 1'b1;
    repeat (5) tick();
    check("postclr.fx_no_emit", log0.size(), 0);
    check("postclr.rr_no_emit", log1.size(), 0);

    // Randomised traffic against the model and scoreboard.
    for (int i = 0; i < 800; i++) begin
      req       = N'($urandom & $urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 63) == 0);
      tick();
    end
    clr = 1'b0; req = '0; out_ready = 1'b1;
    repeat (12) tick();
    check("drain.fx_sb_empty", exp_q0.size(), 0);
    check("drain.rr_sb_empty", exp_q1.size(), 0);
    check("drain.fx_valid", v0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
